// File: rtl/coded_conv_pkg.sv
// coded_conv_pkg: mode encodings and gray/binary helpers shared by the coded converter.
package coded_conv_pkg;
   localparam logic [1:0] MODE_ID  = 2'b00;
   localparam logic [1:0] MODE_B2G = 2'b01;
   localparam logic [1:0] MODE_G2B = 2'b10;
   localparam int MAX_W = 16;

   // Operands are zero-extended to MAX_W, which leaves both conversions unchanged for narrower codes.
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] r;
      r = g;
      for (int i = MAX_W - 2; i >= 0; i--) r[i] = g[i] ^ r[i+1];
      return r;
   endfunction
endpackage

// File: rtl/code_mode_converter.sv
// code_mode_converter: combinational code remap (identity / bin->gray / gray->bin) selected per word.
module code_mode_converter
   import coded_conv_pkg::*;
#(
   parameter int SEL_W = 4
) (
   input  logic [SEL_W-1:0] i_code,
   input  logic [1:0]       i_mode,
   output logic [SEL_W-1:0] o_code
);
   logic [MAX_W-1:0] w_ext;
   assign w_ext  = MAX_W'(i_code);
   assign o_code = (i_mode == MODE_B2G) ? SEL_W'(bin2gray(w_ext)) :
                   (i_mode == MODE_G2B) ? SEL_W'(gray2bin(w_ext)) : i_code;
endmodule

// File: rtl/pipelined_coded_converter.sv
// pipelined_coded_converter: one-hot -> priority code -> mode convert -> one-hot, two-stage valid/ready pipeline
// with invalid-input flag and delivered/error word counters.
module pipelined_coded_converter
   import coded_conv_pkg::*;
#(
   parameter int SEL_W  = 4,
   parameter bit STRICT = 1,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2**SEL_W-1:0] inencoder,
   input  logic [1:0]          mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [2**SEL_W-1:0] outdecoder,
   output logic                out_err,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                clr_cnt,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [CNT_W-1:0]    word_cnt
);
   localparam int W = 2**SEL_W;

   logic             r_s1_v, r_s1_err, r_s2_v, r_s2_err;
   logic [SEL_W-1:0] r_s1_code;
   logic [1:0]       r_s1_mode;
   logic [W-1:0]     r_s2_dec;
   logic [CNT_W-1:0] r_err_cnt, r_word_cnt;
   logic [SEL_W-1:0] w_code, w_conv;
   logic [W-1:0]     w_dec;
   logic             w_err, w_s1_load, w_s2_load, w_acc, w_xfer;

   always_comb begin
      w_code = '0;
      for (int i = 0; i < W; i++) if (inencoder[i]) w_code = SEL_W'(i);
   end

   assign w_err     = $countones(inencoder) != 1;
   assign w_s2_load = !r_s2_v || out_ready;
   assign w_s1_load = !r_s1_v || w_s2_load;
   // Gated by rst_n so the block advertises no space while reset is held.
   assign in_ready  = rst_n && w_s1_load;
   assign w_acc     = in_valid && in_ready;
   assign w_xfer    = r_s2_v && out_ready;

   code_mode_converter #(.SEL_W(SEL_W)) u_conv (
      .i_code (r_s1_code),
      .i_mode (r_s1_mode),
      .o_code (w_conv)
   );

   assign w_dec = (STRICT && r_s1_err) ? '0 : W'(1) << w_conv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_err  <= 1'b0;
         r_s1_code <= '0;
         r_s1_mode <= '0;
         r_s2_v    <= 1'b0;
         r_s2_err  <= 1'b0;
         r_s2_dec  <= '0;
      end else begin
         if (w_s1_load) begin
            r_s1_v    <= w_acc;
            r_s1_err  <= w_err;
            r_s1_code <= w_code;
            r_s1_mode <= mode;
         end
         if (w_s2_load) begin
            r_s2_v   <= r_s1_v;
            r_s2_err <= r_s1_err;
            r_s2_dec <= w_dec;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt  <= '0;
         r_word_cnt <= '0;
      end else if (clr_cnt) begin
         r_err_cnt  <= '0;
         r_word_cnt <= '0;
      end else if (w_xfer) begin
         r_word_cnt <= r_word_cnt + 1'b1;
         if (r_s2_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign outdecoder = r_s2_dec;
   assign out_err    = r_s2_err;
   assign out_valid  = r_s2_v;
   assign err_cnt    = r_err_cnt;
   assign word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_pipelined_coded_converter.sv
// tb_pipelined_coded_converter: three configurations driven by one stream, checked against a word-level model.
module tb_pipelined_coded_converter;
   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr_cnt = 0;
   logic [15:0] din = 0;
   logic [1:0]  mode = 0;
   logic [15:0] od[3];
   logic        oe[3], ov[3], ir[3];
   logic [7:0]  ec[3], wc[3];
   logic [1:0]  ec_c, wc_c;
   int n_cmp = 0, n_err = 0, ncyc = 0;
   int m_wc[3], m_ec[3];
   int cmax[3] = '{255, 255, 3};
   bit strict[3] = '{1, 0, 1};
   typedef struct {logic [15:0] d; logic [1:0] m; int cyc;} ent_t;
   ent_t q[$];
   ent_t cur;

   always #5 clk = ~clk;

   pipelined_coded_converter #(.SEL_W(4), .STRICT(1), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .inencoder(din), .mode(mode), .in_valid(in_valid), .in_ready(ir[0]),
      .outdecoder(od[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready), .clr_cnt(clr_cnt),
      .err_cnt(ec[0]), .word_cnt(wc[0]));
   pipelined_coded_converter #(.SEL_W(4), .STRICT(0), .CNT_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .inencoder(din), .mode(mode), .in_valid(in_valid), .in_ready(ir[1]),
      .outdecoder(od[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready), .clr_cnt(clr_cnt),
      .err_cnt(ec[1]), .word_cnt(wc[1]));
   pipelined_coded_converter #(.SEL_W(4), .STRICT(1), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .inencoder(din), .mode(mode), .in_valid(in_valid), .in_ready(ir[2]),
      .outdecoder(od[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready), .clr_cnt(clr_cnt),
      .err_cnt(ec_c), .word_cnt(wc_c));
   assign ec[2] = 8'(ec_c);
   assign wc[2] = 8'(wc_c);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit bad(input logic [15:0] d);
      return $countones(d) != 1;
   endfunction

   function automatic int exp_out(input logic [15:0] d, input logic [1:0] m, input bit s);
      int x, c, v;
      x = int'(d);
      c = (x == 0) ? 0 : $clog2(x + 1) - 1;
      v = c;
      if (m == 2'd1) v = c ^ (c >> 1);
      else if (m == 2'd2) begin
         v = 0;
         for (int k = 0; k < 4; k++) v ^= c >> k;
      end
      return (s && bad(d)) ? 0 : (1 << v);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_wc = '{0, 0, 0};
         m_ec = '{0, 0, 0};
      end else begin
         ncyc++;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(q.size() < 2 || out_ready));
            check($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(q.size() > 0 ? (ncyc - q[0].cyc >= 2) : 1'b0));
            check($sformatf("word_cnt%0d", k), 32'(wc[k]), 32'(m_wc[k]));
            check($sformatf("err_cnt%0d", k), 32'(ec[k]), 32'(m_ec[k]));
         end
         if (ov[0] && out_ready) begin
            if (q.size() == 0) check("spurious_out", 1, 0);
            else begin
               cur = q.pop_front();
               for (int k = 0; k < 3; k++) begin
                  check($sformatf("outdecoder%0d", k), 32'(od[k]), 32'(exp_out(cur.d, cur.m, strict[k])));
                  check($sformatf("out_err%0d", k), 32'(oe[k]), 32'(bad(cur.d)));
               end
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (clr_cnt) begin
               m_wc[k] = 0;
               m_ec[k] = 0;
            end else if (ov[0] && out_ready) begin
               m_wc[k] = (m_wc[k] + 1) % (cmax[k] + 1);
               if (bad(cur.d) && m_ec[k] < cmax[k]) m_ec[k]++;
            end
         end
         if (in_valid && ir[0]) q.push_back('{din, mode, ncyc});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_out_valid%0d", k), 32'(ov[k]), 0);
         check($sformatf("rst_in_ready%0d", k), 32'(ir[k]), 0);
         check($sformatf("rst_word_cnt%0d", k), 32'(wc[k]), 0);
         check($sformatf("rst_err_cnt%0d", k), 32'(ec[k]), 0);
      end
      step();
      rst_n = 1;
      #1;
      check("in_ready_after_release", 32'(ir[0]), 1);
   endtask

   task automatic send1(input logic [15:0] d, input logic [1:0] m);
      din = d;
      mode = m;
      in_valid = 1;
      step();
      in_valid = 0;
      mode = $urandom_range(0, 3);
   endtask

   initial begin
      out_ready = 1;
      step();
      do_reset();
      send1(16'h0010, 2'b01);
      check("t1_latency", 32'(ov[0]), 0);
      step();
      check("t1_valid", 32'(ov[0]), 1);
      check("t1_out", 32'(od[0]), 32'h0040);
      check("t1_err", 32'(oe[0]), 0);
      step();
      check("t1_word_cnt", 32'(wc[0]), 1);
      send1(16'h0100, 2'b10);
      step();
      check("t2_out", 32'(od[0]), 32'h8000);
      step();
      send1(16'h0000, 2'b00);
      step();
      check("t3_out", 32'(od[0]), 0);
      check("t3_err", 32'(oe[0]), 1);
      step();
      check("t3_err_cnt", 32'(ec[0]), 1);
      send1(16'h0005, 2'b01);
      step();
      check("t3_loose_out", 32'(od[1]), 32'h0008);
      check("t3_loose_err", 32'(oe[1]), 1);
      check("t3_strict_out", 32'(od[0]), 0);
      step();
      out_ready = 0;
      mode = 2'b00;
      in_valid = 1;
      din = 16'h0001;
      step();
      din = 16'h0002;
      step();
      din = 16'h0004;
      check("t4_full", 32'(ir[0]), 0);
      step();
      step();
      check("t4_still_full", 32'(ir[0]), 0);
      check("t4_hold", 32'(od[0]), 32'h0001);
      out_ready = 1;
      step();
      in_valid = 0;
      check("t4_second", 32'(od[0]), 32'h0002);
      step();
      check("t4_third", 32'(od[0]), 32'h0004);
      step();
      check("t4_empty", 32'(ov[0]), 0);
      do_reset();
      din = 16'h0000;
      in_valid = 1;
      repeat (5) step();
      in_valid = 0;
      repeat (3) step();
      check("t5_err_sat", 32'(ec[2]), 3);
      check("t5_word_wrap", 32'(wc[2]), 1);
      send1(16'h0001, 2'b00);
      check("t5_pre_valid", 32'(ov[0]), 0);
      step();
      clr_cnt = 1;
      step();
      clr_cnt = 0;
      check("t5_clr_word", 32'(wc[2]), 0);
      check("t5_clr_err", 32'(ec[2]), 0);
      check("t5_clr_word_a", 32'(wc[0]), 0);
      out_ready = 0;
      in_valid = 1;
      din = 16'h0001;
      step();
      din = 16'h0002;
      step();
      in_valid = 0;
      do_reset();
      repeat (3) step();
      check("t6_no_stale", 32'(ov[0]), 0);
      for (int n = 0; n < 4000; n++) begin
         case ($urandom_range(0, 3))
            0, 1: din = 16'(1 << $urandom_range(0, 15));
            2: din = 16'h0000;
            default: din = 16'($urandom);
         endcase
         mode = $urandom_range(0, 3);
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         clr_cnt = $urandom_range(0, 31) == 0;
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end
      in_valid = 0;
      clr_cnt = 0;
      out_ready = 1;
      for (int n = 0; n < 20 && q.size() > 0; n++) step();
      check("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
